// File: rtl/mutation_engine_if.sv
// Handshake and data bus for mutation_engine: parents and control in, mutated population out.
interface mutation_engine_if #(
  parameter int unsigned GENE_W   = 5,
  parameter int unsigned GENES    = 30,
  parameter int unsigned PARENTS  = 10,
  parameter int unsigned CHILDREN = 5
);
  localparam int unsigned PATH_W = GENES * GENE_W;

  logic                                  start;
  logic [31:0]                           prg_seed;
  logic [7:0]                            mut_rate;
  logic [PARENTS*PATH_W-1:0]             sel_population;
  logic [PARENTS*CHILDREN*PATH_W-1:0]    mutant_pop;
  logic                                  busy;
  logic                                  done;

  modport master (
    output start, prg_seed, mut_rate, sel_population,
    input  mutant_pop, busy, done
  );

  modport slave (
    input  start, prg_seed, mut_rate, sel_population,
    output mutant_pop, busy, done
  );
endinterface

// File: rtl/mutation_engine.sv
// Sequential GA mutation stage: per parent, one elite copy plus CHILDREN-1 children
// each mutated by MUT_STEPS rate-gated gene swaps drawn from a Galois LFSR.
module mutation_engine #(
  parameter int unsigned GENE_W    = 5,
  parameter int unsigned GENES     = 30,
  parameter int unsigned PARENTS   = 10,
  parameter int unsigned CHILDREN  = 5,
  parameter int unsigned MUT_STEPS = 4,
  parameter int unsigned FIX_FIRST = 1
) (
  input logic              clk,
  input logic              reset,
  mutation_engine_if.slave bus
);
  localparam int unsigned PATH_W = GENES * GENE_W;
  localparam int unsigned SLOTS  = PARENTS * CHILDREN;
  localparam int unsigned N      = GENES - FIX_FIRST;
  localparam int unsigned PW     = (PARENTS > 1) ? $clog2(PARENTS) : 1;
  localparam int unsigned CW     = (CHILDREN > 1) ? $clog2(CHILDREN) : 1;
  localparam int unsigned SW     = (MUT_STEPS > 1) ? $clog2(MUT_STEPS) : 1;
  localparam int unsigned GI     = (GENES > 1) ? $clog2(GENES) : 1;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOAD, S_MUTATE, S_WRITE, S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [PARENTS*PATH_W-1:0] sel_q, sel_d;
  logic [7:0]                rate_q, rate_d;
  logic [31:0]               lfsr_q, lfsr_d;
  logic [PW-1:0]             p_q, p_d;
  logic [CW-1:0]             c_q, c_d;
  logic [SW-1:0]             step_q, step_d;
  logic [PATH_W-1:0]         path_q, path_d;
  logic [SLOTS*PATH_W-1:0]   pop_q, pop_d;

  logic [GI-1:0]             gi, gj;
  logic [GENE_W-1:0]         gene_i, gene_j;
  logic                      do_swap;

  // Swap candidates come from the LFSR value held before this cycle's advance.
  always_comb begin
    gi      = GI'(32'(FIX_FIRST) + (32'(lfsr_q[15:8]) % N));
    gj      = GI'(32'(FIX_FIRST) + (32'(lfsr_q[23:16]) % N));
    gene_i  = path_q[(GENES-1-gi)*GENE_W +: GENE_W];
    gene_j  = path_q[(GENES-1-gj)*GENE_W +: GENE_W];
    do_swap = (lfsr_q[7:0] < rate_q) && (gi != gj);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rate_d  = rate_q;
    lfsr_d  = lfsr_q;
    p_d     = p_q;
    c_d     = c_q;
    step_d  = step_q;
    path_d  = path_q;
    pop_d   = pop_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_INIT;
      end
      S_INIT: begin
        sel_d   = bus.sel_population;
        rate_d  = bus.mut_rate;
        lfsr_d  = (bus.prg_seed == '0) ? 32'h1 : bus.prg_seed;
        p_d     = '0;
        c_d     = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        path_d  = sel_q[(PARENTS-1-p_q)*PATH_W +: PATH_W];
        step_d  = '0;
        state_d = (c_q == '0) ? S_WRITE : S_MUTATE;
      end
      S_MUTATE: begin
        if (do_swap) begin
          path_d[(GENES-1-gi)*GENE_W +: GENE_W] = gene_j;
          path_d[(GENES-1-gj)*GENE_W +: GENE_W] = gene_i;
        end
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
        if (step_q == SW'(MUT_STEPS-1)) begin
          state_d = S_WRITE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_WRITE: begin
        pop_d[(SLOTS-1-(p_q*CHILDREN + c_q))*PATH_W +: PATH_W] = path_q;
        if (c_q == CW'(CHILDREN-1)) begin
          c_d = '0;
          p_d = p_q + 1'b1;
          state_d = (p_q == PW'(PARENTS-1)) ? S_DONE : S_LOAD;
        end else begin
          c_d     = c_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      rate_q  <= '0;
      lfsr_q  <= 32'h1;
      p_q     <= '0;
      c_q     <= '0;
      step_q  <= '0;
      path_q  <= '0;
      pop_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rate_q  <= rate_d;
      lfsr_q  <= lfsr_d;
      p_q     <= p_d;
      c_q     <= c_d;
      step_q  <= step_d;
      path_q  <= path_d;
      pop_q   <= pop_d;
    end
  end

  assign bus.mutant_pop = pop_q;
  assign bus.busy       = (state_q == S_INIT) || (state_q == S_LOAD) ||
                          (state_q == S_MUTATE) || (state_q == S_WRITE);
  assign bus.done       = (state_q == S_DONE);
endmodule

// File: tb/tb_mutation_engine.sv
// Directed bench for mutation_engine: default configuration plus a small parameter sweep.
module tb_mutation_engine;
  localparam int G = 30, P = 10, C = 5, M = 4, F = 1, GW = 5;
  localparam int PATHW = G * GW, SL = P * C;
  localparam int L = 261;
  localparam int SG = 8, SP = 2, SC = 3, SM = 1, SF = 0;
  localparam int SPATHW = SG * GW, SSL = SP * SC;
  localparam int SLAT = 17;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mutation_engine_if #(.GENE_W(GW), .GENES(G), .PARENTS(P), .CHILDREN(C)) bus_d ();
  mutation_engine_if #(.GENE_W(GW), .GENES(SG), .PARENTS(SP), .CHILDREN(SC)) bus_s ();

  mutation_engine #(.GENE_W(GW), .GENES(G), .PARENTS(P), .CHILDREN(C),
                    .MUT_STEPS(M), .FIX_FIRST(F))
    dut (.clk(clk), .reset(reset), .bus(bus_d));

  mutation_engine #(.GENE_W(GW), .GENES(SG), .PARENTS(SP), .CHILDREN(SC),
                    .MUT_STEPS(SM), .FIX_FIRST(SF))
    dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] seed;
    logic [7:0]  rate;
    int          kind;
    int          exp_lat;
    bit          copy_chk;
    bit          perm_chk;
    bit          same_prev;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // kind 0: identity tour; kind 1: stride-7 tour rotated by 3 per parent.
  function automatic void fill_par(input int kind, input int pn, input int gn, output int q[$]);
    q = {};
    for (int p = 0; p < pn; p++)
      for (int g = 0; g < gn; g++)
        q.push_back(kind == 0 ? g : (g * 7 + p * 3) % gn);
  endfunction

  // Reference: children p-major, LFSR drawn only on mutation steps.
  function automatic void model(input int gn, input int pn, input int cn, input int mn, input int fx,
                                input logic [31:0] seed, input logic [7:0] rate,
                                input int par[$], output int kid[$]);
    logic [31:0] l;
    int path[$];
    int i, j, t, n;
    l = (seed == 32'h0) ? 32'h1 : seed;
    n = gn - fx;
    kid = {};
    for (int p = 0; p < pn; p++) begin
      for (int c = 0; c < cn; c++) begin
        path = {};
        for (int g = 0; g < gn; g++) path.push_back(par[p*gn + g]);
        if (c > 0) begin
          for (int s = 0; s < mn; s++) begin
            i = fx + int'(l[15:8]) % n;
            j = fx + int'(l[23:16]) % n;
            if (l[7:0] < rate && i != j) begin
              t = path[i]; path[i] = path[j]; path[j] = t;
            end
            l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
          end
        end
        for (int g = 0; g < gn; g++) kid.push_back(path[g]);
      end
    end
  endfunction

  function automatic int gene_of(input int which, input int s, input int g);
    if (which == 0) return int'(bus_d.mutant_pop[(SL-1-s)*PATHW + (G-1-g)*GW +: GW]);
    return int'(bus_s.mutant_pop[(SSL-1-s)*SPATHW + (SG-1-g)*GW +: GW]);
  endfunction

  function automatic bit busy_of(input int which);
    return (which == 0) ? bus_d.busy : bus_s.busy;
  endfunction

  function automatic bit done_of(input int which);
    return (which == 0) ? bus_d.done : bus_s.done;
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which == 0) bus_d.start = v; else bus_s.start = v;
  endtask

  task automatic set_inputs(input int which, input logic [31:0] seed, input logic [7:0] rate,
                            input int par[$]);
    if (which == 0) begin
      bus_d.prg_seed = seed;
      bus_d.mut_rate = rate;
      for (int p = 0; p < P; p++)
        for (int g = 0; g < G; g++)
          bus_d.sel_population[(P-1-p)*PATHW + (G-1-g)*GW +: GW] = 5'(par[p*G + g]);
    end else begin
      bus_s.prg_seed = seed;
      bus_s.mut_rate = rate;
      for (int p = 0; p < SP; p++)
        for (int g = 0; g < SG; g++)
          bus_s.sel_population[(SP-1-p)*SPATHW + (SG-1-g)*GW +: GW] = 5'(par[p*SG + g]);
    end
  endtask

  task automatic compare_pop(input int which, input string tag, input int exp[$]);
    int gn, sn, bad, g0;
    gn = (which == 0) ? G : SG;
    sn = (which == 0) ? SL : SSL;
    for (int s = 0; s < sn; s++) begin
      bad = -1;
      for (int g = 0; g < gn; g++)
        if (bad < 0 && gene_of(which, s, g) != exp[s*gn + g]) bad = g;
      g0 = (bad < 0) ? 0 : bad;
      chk($sformatf("%s slot%0d gene%0d", tag, s, g0), gene_of(which, s, g0), exp[s*gn + g0]);
    end
  endtask

  task automatic run(input int which, input logic [31:0] seed, input logic [7:0] rate,
                     input int par[$], input int exp_lat, input string tag);
    int lat, dcnt, bcnt;
    set_inputs(which, seed, rate, par);
    @(posedge clk); #1 set_start(which, 1'b1);
    @(posedge clk); #1 set_start(which, 1'b0);
    lat = -1; dcnt = 0; bcnt = 0;
    for (int k = 0; k < exp_lat + 10; k++) begin
      @(negedge clk);
      if (busy_of(which)) bcnt++;
      if (done_of(which)) begin
        dcnt++;
        if (lat < 0) lat = k;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " done pulses"}, dcnt, 1);
    chk({tag, " busy cycles"}, bcnt, exp_lat);
  endtask

  vec_t vt[5];
  int par[$], exp[$], expb[$], copy[$];
  logic [SL*PATHW-1:0] prev_pop;
  bit [63:0] seen;
  int hand[8];

  initial begin
    int dcnt, bcnt;
    vt[0] = '{32'hDEAD_BEEF, 8'd0,   1, L, 1'b1, 1'b1, 1'b0};
    vt[1] = '{32'h1234_5678, 8'd255, 0, L, 1'b0, 1'b1, 1'b0};
    vt[2] = '{32'h0000_0000, 8'd200, 1, L, 1'b0, 1'b1, 1'b0};
    vt[3] = '{32'h0000_0001, 8'd200, 1, L, 1'b0, 1'b1, 1'b1};
    vt[4] = '{32'hCAFE_F00D, 8'd128, 1, L, 1'b0, 1'b1, 1'b0};
    hand  = '{5, 7, 6, 0, 4, 3, 2, 1};

    bus_d.start = 1'b0; bus_d.prg_seed = '0; bus_d.mut_rate = '0; bus_d.sel_population = '0;
    bus_s.start = 1'b0; bus_s.prg_seed = '0; bus_s.mut_rate = '0; bus_s.sel_population = '0;
    prev_pop = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset pop zero", longint'(bus_d.mutant_pop == '0), 1);
    chk("reset busy", bus_d.busy, 0);
    chk("reset done", bus_d.done, 0);
    chk("reset sweep pop zero", longint'(bus_s.mutant_pop == '0), 1);

    for (int v = 0; v < 5; v++) begin
      fill_par(vt[v].kind, P, G, par);
      model(G, P, C, M, F, vt[v].seed, vt[v].rate, par, exp);
      run(0, vt[v].seed, vt[v].rate, par, vt[v].exp_lat, $sformatf("vec%0d", v));
      compare_pop(0, $sformatf("vec%0d model", v), exp);
      if (vt[v].copy_chk) begin
        copy = {};
        for (int s = 0; s < SL; s++)
          for (int g = 0; g < G; g++) copy.push_back(par[(s / C)*G + g]);
        compare_pop(0, $sformatf("vec%0d copy", v), copy);
      end
      if (vt[v].perm_chk) begin
        for (int s = 0; s < SL; s++) begin
          seen = '0;
          for (int g = 0; g < G; g++) seen[gene_of(0, s, g)] = 1'b1;
          chk($sformatf("vec%0d perm slot%0d", v, s), longint'(seen), (64'd1 << G) - 1);
          chk($sformatf("vec%0d gene0 slot%0d", v, s), gene_of(0, s, 0), par[(s / C)*G]);
        end
      end
      if (vt[v].same_prev)
        chk($sformatf("vec%0d same as previous", v), longint'(bus_d.mutant_pop == prev_pop), 1);
      prev_pop = bus_d.mutant_pop;
    end

    // start held high: two back-to-back runs, inputs changed after the first INIT.
    fill_par(1, P, G, par);
    model(G, P, C, M, F, 32'hA5A5_1234, 8'd90, par, exp);
    fill_par(0, P, G, copy);
    model(G, P, C, M, F, 32'h0F0F_7777, 8'd170, copy, expb);
    set_inputs(0, 32'hA5A5_1234, 8'd90, par);
    @(posedge clk); #1 bus_d.start = 1'b1;
    @(posedge clk);
    dcnt = 0;
    for (int k = 0; k < 2*L + 12; k++) begin
      @(negedge clk);
      if (k == 1) set_inputs(0, 32'h0F0F_7777, 8'd170, copy);
      if (bus_d.done) begin
        dcnt++;
        if (dcnt == 1) begin
          chk("held first done", k, L);
          compare_pop(0, "held run1", exp);
        end else begin
          chk("held second done", k, 2*L + 2);
          compare_pop(0, "held run2", expb);
          bus_d.start = 1'b0;
        end
      end
    end
    bus_d.start = 1'b0;
    chk("held done count", dcnt, 2);

    // Reset mid-run, with start asserted in the reset cycle.
    fill_par(1, P, G, par);
    model(G, P, C, M, F, 32'h7777_0001, 8'd255, par, exp);
    set_inputs(0, 32'h7777_0001, 8'd255, par);
    @(posedge clk); #1 bus_d.start = 1'b1;
    @(posedge clk); #1 bus_d.start = 1'b0;
    for (int k = 0; k < 100; k++) @(negedge clk);
    reset = 1'b1; bus_d.start = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus_d.start = 1'b0;
    chk("midreset pop zero", longint'(bus_d.mutant_pop == '0), 1);
    chk("midreset busy", bus_d.busy, 0);
    chk("midreset done", bus_d.done, 0);
    dcnt = 0; bcnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus_d.done) dcnt++;
      if (bus_d.busy) bcnt++;
    end
    chk("midreset no done", dcnt, 0);
    chk("midreset stays idle", bcnt, 0);
    run(0, 32'h7777_0001, 8'd255, par, L, "restart");
    compare_pop(0, "restart model", exp);

    // Parameter sweep: GENES=8, PARENTS=2, CHILDREN=3, MUT_STEPS=1, FIX_FIRST=0.
    fill_par(1, SP, SG, par);
    model(SG, SP, SC, SM, SF, 32'h0003_0000, 8'd255, par, exp);
    run(1, 32'h0003_0000, 8'd255, par, SLAT, "sweep0");
    compare_pop(1, "sweep0 model", exp);
    for (int g = 0; g < SG; g++)
      chk($sformatf("sweep0 hand slot1 gene%0d", g), gene_of(1, 1, g), hand[g]);
    model(SG, SP, SC, SM, SF, 32'hDEAD_BEEF, 8'd128, par, exp);
    run(1, 32'hDEAD_BEEF, 8'd128, par, SLAT, "sweep1");
    compare_pop(1, "sweep1 model", exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
